// File: rtl/ptw_mem_responder_pkg.sv
// +--------------------------------------------------------------------------+
// | ptw_mem_responder_pkg : shared FSM encoding and AXI read constants        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package ptw_mem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_ACK  = 2'd3
  } ptw_state_e;

  localparam logic [7:0] c_AXI_LEN_SINGLE = 8'd0;
  localparam logic [2:0] c_AXI_SIZE_8B    = 3'b011;
  localparam logic [1:0] c_AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] c_AXI_RESP_OKAY  = 2'b00;

  // PTEs are 8 bytes, so every fetch is a naturally aligned doubleword.
  function automatic logic [63:0] align_dword(input logic [63:0] addr);
    return {addr[63:3], 3'b000};
  endfunction

endpackage

`default_nettype wire

// File: rtl/ptw_req_slot.sv
// +--------------------------------------------------------------------------+
// | ptw_req_slot : one-deep pending PTE request holder (valid + address)      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ptw_req_slot (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture_i,
  input  logic [63:0] addr_i,
  input  logic        free_i,
  output logic        valid_o,
  output logic [63:0] addr_o
);

  logic        valid_q;
  logic [63:0] addr_q;

  // A capture in the same cycle as free refills the slot (next-level walk).
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= 64'h0;
    end else if (capture_i && (!valid_q || free_i)) begin
      valid_q <= 1'b1;
      addr_q  <= addr_i;
    end else if (free_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;

endmodule

`default_nettype wire

// File: rtl/ptw_mem_responder.sv
// +--------------------------------------------------------------------------+
// | ptw_mem_responder : two-port PTE fetch engine over a single AXI4 read     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module ptw_mem_responder
  import ptw_mem_responder_pkg::*;
#(
  parameter logic [3:0] AXI_ID = 4'd2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tlb_start_burst_port0,
  input  logic        tlb_start_burst_port1,
  input  logic [63:0] tlb_address_port0,
  input  logic [63:0] tlb_address_port1,
  output logic        mem_ack_port0,
  output logic        mem_ack_port1,
  output logic [63:0] write_data_axi,
  output logic        mem_err,
  output logic        ptw_busy,
  output logic        proto_err,
  output logic        m_arvalid,
  input  logic        m_arready,
  output logic [63:0] m_araddr,
  output logic [3:0]  m_arid,
  output logic [7:0]  m_arlen,
  output logic [2:0]  m_arsize,
  output logic [1:0]  m_arburst,
  input  logic        m_rvalid,
  output logic        m_rready,
  input  logic [63:0] m_rdata,
  input  logic [1:0]  m_rresp,
  input  logic        m_rlast,
  input  logic [3:0]  m_rid
);

  ptw_state_e  state_q, state_d;
  logic        served_q, served_d;
  logic [63:0] rdata_q;
  logic [1:0]  rresp_q;
  logic        proto_err_q;

  logic [1:0]  start;
  logic [1:0]  pend;
  logic [1:0]  slot_valid;
  logic [1:0]  slot_free;
  logic [1:0]  slot_reject;
  logic [63:0] start_addr [2];
  logic [63:0] slot_addr  [2];
  logic        r_beat;
  logic        in_ack;
  logic        resp_bad;

  assign start         = {tlb_start_burst_port1, tlb_start_burst_port0};
  assign start_addr[0] = tlb_address_port0;
  assign start_addr[1] = tlb_address_port1;
  assign pend          = slot_valid | start;

  for (genvar k = 0; k < 2; k++) begin : g_slot
    assign slot_free[k]   = (state_q == ST_ACK) && (served_q == 1'(k));
    assign slot_reject[k] = start[k] && slot_valid[k] && !slot_free[k];

    ptw_req_slot u_slot (
      .clk       (clk),
      .rst       (rst),
      .capture_i (start[k]),
      .addr_i    (start_addr[k]),
      .free_i    (slot_free[k]),
      .valid_o   (slot_valid[k]),
      .addr_o    (slot_addr[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      served_q    <= 1'b0;
      rdata_q     <= 64'h0;
      rresp_q     <= c_AXI_RESP_OKAY;
      proto_err_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      served_q <= served_d;
      if (r_beat) begin
        rdata_q <= m_rdata;
        rresp_q <= m_rresp;
      end
      // A malformed beat is still consumed as the response; only flagged.
      if ((|slot_reject) || (r_beat && (!m_rlast || (m_rid != AXI_ID)))) begin
        proto_err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    served_d = served_q;
    case (state_q)
      ST_IDLE: begin
        if (pend[1]) begin
          state_d  = ST_AR;
          served_d = 1'b1;
        end else if (pend[0]) begin
          state_d  = ST_AR;
          served_d = 1'b0;
        end
      end
      ST_AR:   if (m_arready) state_d = ST_R;
      ST_R:    if (m_rvalid)  state_d = ST_ACK;
      ST_ACK: begin
        // The other port goes next so a chained walk cannot starve it.
        if (pend[~served_q]) begin
          state_d  = ST_AR;
          served_d = ~served_q;
        end else if (start[served_q]) begin
          state_d  = ST_AR;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign r_beat   = (state_q == ST_R) && m_rvalid;
  assign in_ack   = (state_q == ST_ACK);
  assign resp_bad = (rresp_q != c_AXI_RESP_OKAY);

  assign m_arvalid = (state_q == ST_AR);
  assign m_araddr  = m_arvalid ? align_dword(slot_addr[served_q]) : 64'h0;
  assign m_arid    = AXI_ID;
  assign m_arlen   = c_AXI_LEN_SINGLE;
  assign m_arsize  = c_AXI_SIZE_8B;
  assign m_arburst = c_AXI_BURST_INCR;
  assign m_rready  = (state_q == ST_R);

  assign mem_ack_port0  = in_ack && !served_q;
  assign mem_ack_port1  = in_ack && served_q;
  assign mem_err        = in_ack && resp_bad;
  assign write_data_axi = (in_ack && !resp_bad) ? rdata_q : 64'h0;
  assign ptw_busy       = (state_q != ST_IDLE) || (|slot_valid);
  assign proto_err      = proto_err_q;

endmodule

`default_nettype wire

// File: tb/tb_ptw_mem_responder.sv
// +--------------------------------------------------------------------------+
// | tb_ptw_mem_responder : vector table, corner sequences, random + model    |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_ptw_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic [63:0] addr0, addr1;
  logic        mem_ack_port0, mem_ack_port1, mem_err, ptw_busy, proto_err;
  logic [63:0] write_data_axi;
  logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
  logic [63:0] m_araddr, m_rdata;
  logic [3:0]  m_arid, m_rid;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst, m_rresp;

  always #5 clk = ~clk;

  ptw_mem_responder #(.AXI_ID(4'd2)) dut (
    .clk(clk), .rst(rst),
    .tlb_start_burst_port0(start0), .tlb_start_burst_port1(start1),
    .tlb_address_port0(addr0), .tlb_address_port1(addr1),
    .mem_ack_port0(mem_ack_port0), .mem_ack_port1(mem_ack_port1),
    .write_data_axi(write_data_axi), .mem_err(mem_err),
    .ptw_busy(ptw_busy), .proto_err(proto_err),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
    .m_arid(m_arid), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata),
    .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rid(m_rid)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  // slave and bookkeeping state
  int          ar_cnt, r_cnt, cur_ar_wait, cur_r_wait;
  bit          rpend, cfg_fixed;
  logic [63:0] r_data, cfg_data;
  logic [1:0]  r_resp, cfg_resp;
  logic        cfg_rlast;
  logic [3:0]  cfg_rid;
  int          ack_cnt0, ack_cnt1, ar_hs_cnt;
  logic [63:0] ar_log[$];
  int          ack_log[$];

  // reference model state
  bit          model_on, exp_proto, in_svc;
  bit          pend[2];
  logic [63:0] paddr[2];
  int          svc;

  typedef struct {
    bit          port;
    logic [63:0] addr;
    logic [63:0] data;
    logic [1:0]  resp;
    int          arw;
    logic [63:0] exp_araddr;
    logic [63:0] exp_wdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [63:0] dat(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_0F0F, a[63:32] + 32'h0000_1357};
  endfunction

  function automatic logic [63:0] dw(input logic [63:0] a);
    return a & ~64'h7;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    logic        p_ar_hs, p_r_hs, p_arv, p_rst, e, last;
    logic [63:0] p_araddr;
    logic [1:0]  p_start, p_ack;
    logic [63:0] p_addr[2];
    p_ar_hs  = m_arvalid & m_arready;
    p_r_hs   = m_rvalid & m_rready;
    p_arv    = m_arvalid;
    p_rst    = rst;
    p_araddr = m_araddr;
    p_start  = {start1, start0};
    p_ack    = {mem_ack_port1, mem_ack_port0};
    p_addr[0] = addr0;
    p_addr[1] = addr1;
    @(posedge clk);
    #1;
    cyc++;
    start0 = 1'b0;
    start1 = 1'b0;
    if (p_ack[0]) begin ack_cnt0++; ack_log.push_back(0); end
    if (p_ack[1]) begin ack_cnt1++; ack_log.push_back(1); end
    if (p_ar_hs) begin ar_hs_cnt++; ar_log.push_back(p_araddr); end
    if (p_rst) begin
      rpend = 1'b0; ar_cnt = 0; r_cnt = 0;
    end else begin
      if (p_ar_hs) begin
        rpend = 1'b1; r_cnt = 0; ar_cnt = 0;
        if (cfg_fixed) begin
          r_data = cfg_data; r_resp = cfg_resp;
        end else begin
          r_data = dat(p_araddr);
          r_resp = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b00;
          cur_ar_wait = $urandom_range(0, 2);
          cur_r_wait  = $urandom_range(0, 2);
        end
      end else if (p_arv) begin
        ar_cnt++;
      end
      if (p_r_hs) rpend = 1'b0;
      else if (rpend && !p_ar_hs) r_cnt++;
    end
    m_arready = m_arvalid && (ar_cnt >= cur_ar_wait);
    m_rvalid  = rpend && (r_cnt >= cur_r_wait);
    m_rdata   = m_rvalid ? r_data : 64'h0;
    m_rresp   = m_rvalid ? r_resp : 2'b00;
    m_rlast   = cfg_rlast;
    m_rid     = cfg_rid;
    if (model_on) begin
      if (p_rst) begin
        pend[0] = 0; pend[1] = 0; exp_proto = 0; in_svc = 0;
      end else begin
        for (int k = 0; k < 2; k++) begin
          if (p_ack[k]) pend[k] = 0;
          if (p_start[k]) begin
            if (pend[k]) exp_proto = 1;
            else begin pend[k] = 1; paddr[k] = p_addr[k]; end
          end
        end
      end
      chk("m_proto_err", proto_err, exp_proto);
      chk("m_busy", ptw_busy, pend[0] | pend[1]);
      if (m_arvalid && !p_arv) begin
        if (p_ack != 2'b00) begin
          last = p_ack[1];
          e = pend[!last] ? !last : last;
        end else begin
          e = pend[1];
        end
        chk("m_ar_addr", m_araddr, dw(paddr[e]));
        svc = e; in_svc = 1;
      end
      if (mem_ack_port0 || mem_ack_port1) begin
        chk("m_ack_port", {mem_ack_port1, mem_ack_port0},
            !in_svc ? 2'b00 : (svc != 0 ? 2'b10 : 2'b01));
        chk("m_ack_err", mem_err, r_resp != 2'b00);
        chk("m_ack_data", write_data_axi, (r_resp != 2'b00) ? 64'h0 : dat(dw(paddr[svc])));
        in_svc = 0;
      end else begin
        chk("m_idle_out", {63'h0, mem_err} | write_data_axi, 64'h0);
      end
    end
  endtask

  task automatic wait_rready(input string name);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (m_rready) ok = 1;
      else tick();
    end
    chk(name, ok, 1'b1);
  endtask

  task automatic wait_ack(input string name);
    bit ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (mem_ack_port0 || mem_ack_port1) ok = 1;
      else tick();
    end
    chk(name, ok, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int          t0, first_ar, ack_at, a0, a1, ao;
    bit          held_ok, ar_done;
    logic [63:0] ar0, ack_data;
    logic        ack_e;

    vecs[0] = '{0, 64'h8000_1238, 64'h0000_0000_2000_00CF, 2'b00, 0,
                64'h8000_1238, 64'h0000_0000_2000_00CF, 0, 3};
    vecs[1] = '{1, 64'h3005, 64'hDEAD_BEEF, 2'b10, 0, 64'h3000, 64'h0, 1, 3};
    vecs[2] = '{0, 64'h4000_0010, 64'h1234_5678_9ABC_DEF1, 2'b00, 5,
                64'h4000_0010, 64'h1234_5678_9ABC_DEF1, 0, 8};
    vecs[3] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h5555, 2'b11, 0,
                64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 1, 3};
    vecs[4] = '{1, 64'h0000_0001_0000_0007, 64'h0A0B, 2'b01, 1,
                64'h0000_0001_0000_0000, 64'h0, 1, 4};

    rst = 1'b1; start0 = 0; start1 = 0; addr0 = 0; addr1 = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0; m_rlast = 1; m_rid = 4'd2;
    cfg_fixed = 1; cfg_data = 0; cfg_resp = 0; cfg_rlast = 1; cfg_rid = 4'd2;
    cur_ar_wait = 0; cur_r_wait = 0; rpend = 0; ar_cnt = 0; r_cnt = 0;
    r_data = 0; r_resp = 0; model_on = 0;
    do_reset();

    chk("rst_arvalid", m_arvalid, 0);
    chk("rst_araddr", m_araddr, 0);
    chk("rst_rready", m_rready, 0);
    chk("rst_acks", {mem_ack_port1, mem_ack_port0}, 0);
    chk("rst_wdata", write_data_axi, 0);
    chk("rst_err", mem_err, 0);
    chk("rst_busy", ptw_busy, 0);
    chk("rst_proto", proto_err, 0);
    chk("rst_arid", m_arid, 4'd2);
    chk("rst_arlen", m_arlen, 8'd0);
    chk("rst_arsize", m_arsize, 3'b011);
    chk("rst_arburst", m_arburst, 2'b01);

    // table of single transactions
    for (int v = 0; v < 5; v++) begin
      cfg_data = vecs[v].data; cfg_resp = vecs[v].resp;
      cur_ar_wait = vecs[v].arw; cur_r_wait = 0;
      if (vecs[v].port) begin start1 = 1; addr1 = vecs[v].addr; end
      else begin start0 = 1; addr0 = vecs[v].addr; end
      t0 = cyc; a0 = ack_cnt0; a1 = ack_cnt1;
      first_ar = -1; ack_at = -1; held_ok = 1; ar_done = 0; ar0 = 0;
      ack_data = 0; ack_e = 0;
      tick();
      for (int i = 0; i < 15; i++) begin
        if (m_arvalid && first_ar < 0) begin first_ar = cyc - t0; ar0 = m_araddr; end
        if (first_ar >= 0 && !ar_done) begin
          if (!m_arvalid || m_araddr !== ar0) held_ok = 0;
          if (m_arready) ar_done = 1;
        end
        if ((vecs[v].port ? mem_ack_port1 : mem_ack_port0) && ack_at < 0) begin
          ack_at = cyc - t0; ack_data = write_data_axi; ack_e = mem_err;
        end
        tick();
      end
      chk($sformatf("vec%0d_ar_lat", v), first_ar, 1);
      chk($sformatf("vec%0d_araddr", v), ar0, vecs[v].exp_araddr);
      chk($sformatf("vec%0d_ar_held", v), held_ok, 1);
      chk($sformatf("vec%0d_ack_lat", v), ack_at, vecs[v].exp_lat);
      chk($sformatf("vec%0d_data", v), ack_data, vecs[v].exp_wdata);
      chk($sformatf("vec%0d_err", v), ack_e, vecs[v].exp_err);
      chk($sformatf("vec%0d_ack_cnt", v),
          vecs[v].port ? (ack_cnt1 - a1) : (ack_cnt0 - a0), 1);
      chk($sformatf("vec%0d_other_ack", v),
          vecs[v].port ? (ack_cnt0 - a0) : (ack_cnt1 - a1), 0);
      chk($sformatf("vec%0d_proto", v), proto_err, 0);
    end

    // simultaneous starts: port1 first, both served
    cfg_data = 64'h77; cfg_resp = 0; cur_ar_wait = 0;
    ar_log.delete(); ack_log.delete();
    start0 = 1; addr0 = 64'h1000; start1 = 1; addr1 = 64'h2000;
    tick();
    for (int i = 0; i < 15; i++) tick();
    chk("both_ar_cnt", ar_log.size(), 2);
    chk("both_ar_first", ar_log[0], 64'h2000);
    chk("both_ar_second", ar_log[1], 64'h1000);
    chk("both_ack_cnt", ack_log.size(), 2);
    chk("both_ack_first", ack_log[0], 1);
    chk("both_ack_second", ack_log[1], 0);

    // duplicate start while in R, then a chained start in the ACK cycle
    cfg_data = 64'h99; cur_r_wait = 2; ar_log.delete();
    ao = ack_cnt0;
    start0 = 1; addr0 = 64'h5000;
    tick();
    wait_rready("dup_wait_r");
    start0 = 1; addr0 = 64'h6000;
    tick();
    chk("dup_proto", proto_err, 1);
    wait_ack("dup_wait_ack");
    chk("dup_ack_port0", mem_ack_port0, 1);
    chk("dup_ar_cnt", ar_log.size(), 1);
    chk("dup_ar_orig", ar_log[0], 64'h5000);
    start0 = 1; addr0 = 64'h7008;
    tick();
    chk("chain_arvalid", m_arvalid, 1);
    chk("chain_araddr", m_araddr, 64'h7008);
    for (int i = 0; i < 12; i++) tick();
    chk("chain_acks", ack_cnt0 - ao, 2);
    chk("chain_ar_total", ar_log.size(), 2);
    chk("proto_sticky", proto_err, 1);
    do_reset();
    chk("proto_cleared", proto_err, 0);

    // rlast=0 beat still completes but flags a protocol error
    cur_r_wait = 0; cfg_rlast = 0; cfg_data = 64'hABC;
    start1 = 1; addr1 = 64'h9000;
    tick();
    wait_ack("rlast_wait_ack");
    chk("rlast_data", write_data_axi, 64'hABC);
    tick();
    chk("rlast_proto", proto_err, 1);
    cfg_rlast = 1;
    do_reset();

    // reset while in R drops the transaction
    cur_r_wait = 3; ao = ack_cnt0 + ack_cnt1;
    start0 = 1; addr0 = 64'hA000;
    tick();
    wait_rready("rstR_wait_r");
    rst = 1;
    tick();
    rst = 0;
    chk("rstR_rready", m_rready, 0);
    chk("rstR_arvalid", m_arvalid, 0);
    chk("rstR_ack", {mem_ack_port1, mem_ack_port0}, 0);
    chk("rstR_busy", ptw_busy, 0);
    for (int i = 0; i < 6; i++) tick();
    chk("rstR_no_ack", ack_cnt0 + ack_cnt1 - ao, 0);

    // randomized traffic against the reference model
    cfg_fixed = 0; cur_ar_wait = 0; cur_r_wait = 0;
    pend[0] = 0; pend[1] = 0; exp_proto = 0; in_svc = 0; svc = 0;
    model_on = 1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (((!pend[0] || mem_ack_port0) && $urandom_range(0, 4) == 0) ||
          $urandom_range(0, 299) == 0) begin
        start0 = 1; addr0 = {$urandom, $urandom} & ~(64'h1 << 40);
      end
      if (((!pend[1] || mem_ack_port1) && $urandom_range(0, 4) == 0) ||
          $urandom_range(0, 299) == 0) begin
        start1 = 1; addr1 = {$urandom, $urandom} | (64'h1 << 40);
      end
      tick();
    end
    for (int i = 0; i < 40; i++) tick();
    chk("drain_busy", ptw_busy, 0);
    model_on = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
